// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states, byte strobes.
// Size encodings double as the load-mux select in dmem_responder.
package dmem_pkg;

   localparam logic [1:0] SZ_WORD = 2'd0;
   localparam logic [1:0] SZ_BYTE = 2'd1;
   localparam logic [1:0] SZ_HALF = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

   // Little-endian lane strobes; size 3 falls through to word, low bits below the size are ignored.
   function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] a);
      case (size)
         SZ_BYTE: return 4'b0001 << a;
         SZ_HALF: return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous byte-strobed write, combinational read by word index.
// Contents are deliberately not reset.
module dmem_array #(
   parameter int unsigned DEPTH_WORDS = 1024,
   localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [3:0]    strb_i,
   input  logic [AW-1:0] idx_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (strb_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU load/store port: one request at a time, fixed LATENCY, held response.
// Optional misalignment trapping is compiled in with `define DMEM_ALIGN_CHECK_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_sign_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int unsigned AW       = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, sign_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, wdata_q;

   logic        accept, commit, mis;
   logic        acc_we, acc_sign;
   logic [1:0]  acc_size;
   logic [31:0] acc_addr, acc_wdata, wlanes, rd_word, load_val, sh8, sh16;
   logic [3:0]  strb;
   logic        unused_addr;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      accept      = 1'b0;
      commit      = 1'b0;
      req_ready_o = (state_q == S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               accept = 1'b1;
               cnt_d  = CNT_INIT;
               if (LATENCY == 1) begin
                  state_d = S_RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_RESP;
               commit  = 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         sign_q  <= 1'b0;
         size_q  <= SZ_WORD;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q    <= req_we_i;
            sign_q  <= req_sign_i;
            size_q  <= req_size_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
         end
      end
   end

   // With LATENCY==1 the store commits on the accept edge, before the latches hold the request.
   assign acc_we    = (state_q == S_IDLE) ? req_we_i    : we_q;
   assign acc_sign  = (state_q == S_IDLE) ? req_sign_i  : sign_q;
   assign acc_size  = (state_q == S_IDLE) ? req_size_i  : size_q;
   assign acc_addr  = (state_q == S_IDLE) ? req_addr_i  : addr_q;
   assign acc_wdata = (state_q == S_IDLE) ? req_wdata_i : wdata_q;

`ifdef DMEM_ALIGN_CHECK_EN
   assign mis = ((acc_size == SZ_HALF) && acc_addr[0]) ||
                ((acc_size != SZ_BYTE) && (acc_size != SZ_HALF) && (acc_addr[1:0] != 2'b00));
`else
   assign mis = 1'b0;
`endif

   assign strb        = byte_strobe(acc_size, acc_addr[1:0]);
   assign unused_addr = ^acc_addr[31:AW+2];

   always_comb begin
      wlanes = acc_wdata;
      case (acc_size)
         SZ_BYTE: wlanes = {4{acc_wdata[7:0]}};
         SZ_HALF: wlanes = {2{acc_wdata[15:0]}};
         default: wlanes = acc_wdata;
      endcase
   end

   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_array (
      .clk_i   (clk_i),
      .we_i    (commit && acc_we && !mis),
      .strb_i  (strb),
      .idx_i   (acc_addr[AW+1:2]),
      .wdata_i (wlanes),
      .rdata_o (rd_word)
   );

   assign sh8  = rd_word >> {acc_addr[1:0], 3'b000};
   assign sh16 = rd_word >> {acc_addr[1], 4'b0000};

   always_comb begin
      load_val = rd_word;
      case (acc_size)
         SZ_BYTE: load_val = {{24{acc_sign & sh8[7]}}, sh8[7:0]};
         SZ_HALF: load_val = {{16{acc_sign & sh16[15]}}, sh16[15:0]};
         default: load_val = rd_word;
      endcase
   end

   // Storage only changes on a commit edge, so the combinational read is stable for the whole RESP.
   assign rsp_valid_o = (state_q == S_RESP);
   assign rsp_rdata_o = (rsp_valid_o && !acc_we && !mis) ? load_val : 32'd0;
   assign rsp_err_o   = rsp_valid_o && mis;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table of load/store vectors plus hand sequences
// for backpressure, reset mid-store, misalignment and address wrap.
module tb_dmem_responder;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned LAT   = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_sign = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
   logic [31:0] rsp_rdata;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sign;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      logic        exp_err;
   } vec_t;

   vec_t vecs[18];

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_we_i    (req_we),
      .req_size_i  (req_size),
      .req_sign_i  (req_sign),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic drive(input vec_t v);
      req_we    = v.we;
      req_size  = v.size;
      req_sign  = v.sign;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      req_valid = 1'b1;
   endtask

   // Accept, scramble the request pins, wait for the response; returns cycles from request to rsp_valid.
   task automatic issue(input vec_t v, output int cyc);
      drive(v);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_we    = ~v.we;
      req_addr  = v.addr ^ 32'h0000_0005;
      req_wdata = ~v.wdata;
      req_size  = v.size + 2'd1;
      req_sign  = ~v.sign;
      cyc = 1;
      while (!rsp_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic do_txn(input vec_t v, input string name);
      int cyc;
      issue(v, cyc);
      check({name, " latency"}, 32'(cyc), 32'(LAT));
      check({name, " rdata"}, rsp_rdata, v.exp);
      check({name, " err"}, {31'd0, rsp_err}, {31'd0, v.exp_err});
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout");
      $fatal(1);
   end

   initial begin
      vec_t v;
      int   cyc;
      bit   seen;

      vecs[0]  = '{1'b1, 2'd0, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 2'd1, 1'b0, 32'h13,   32'h00000080, 32'h0,        1'b0};
      vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h13,   32'h0,        32'hFFFFFF80, 1'b0};
      vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h13,   32'h0,        32'h00000080, 1'b0};
      vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h10,   32'h0,        32'h80ADBEEF, 1'b0};
      vecs[6]  = '{1'b1, 2'd0, 1'b0, 32'h20,   32'hCAFEF00D, 32'h0,        1'b0};
      vecs[7]  = '{1'b1, 2'd2, 1'b0, 32'h22,   32'h00001234, 32'h0,        1'b0};
      vecs[8]  = '{1'b0, 2'd0, 1'b0, 32'h20,   32'h0,        32'h1234F00D, 1'b0};
      vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h22,   32'h00008001, 32'h0,        1'b0};
      vecs[10] = '{1'b0, 2'd2, 1'b1, 32'h22,   32'h0,        32'hFFFF8001, 1'b0};
      vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h22,   32'h0,        32'h00008001, 1'b0};
      vecs[12] = '{1'b0, 2'd1, 1'b0, 32'h11,   32'h0,        32'h000000BE, 1'b0};
      vecs[13] = '{1'b1, 2'd0, 1'b0, 32'h40,   32'h11223344, 32'h0,        1'b0};
      vecs[14] = '{1'b0, 2'd3, 1'b1, 32'h40,   32'h0,        32'h11223344, 1'b0};
      vecs[15] = '{1'b0, 2'd2, 1'b1, 32'h20,   32'h0,        32'hFFFFF00D, 1'b0};
      vecs[16] = '{1'b1, 2'd0, 1'b0, 32'h1000, 32'h55667788, 32'h0,        1'b0};
      vecs[17] = '{1'b0, 2'd0, 1'b0, 32'h0,    32'h0,        32'h55667788, 1'b0};

      // Reset state
      #12;
      check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("reset req_ready", {31'd0, req_ready}, 32'd1);
      check("reset rsp_rdata", rsp_rdata, 32'd0);
      check("reset rsp_err", {31'd0, rsp_err}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 18; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

      // Backpressure: response held for 5 cycles
      rsp_ready = 1'b0;
      v = '{1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0};
      issue(v, cyc);
      check("bp latency", 32'(cyc), 32'(LAT));
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check($sformatf("bp hold%0d valid", i), {31'd0, rsp_valid}, 32'd1);
         check($sformatf("bp hold%0d rdata", i), rsp_rdata, 32'h80ADBEEF);
         check($sformatf("bp hold%0d req_ready", i), {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp release req_ready", {31'd0, req_ready}, 32'd1);
      check("bp release rsp_valid", {31'd0, rsp_valid}, 32'd0);

      // Reset while a store sits in WAIT
      v = '{1'b1, 2'd0, 1'b0, 32'h40, 32'hAAAAAAAA, 32'h0, 1'b0};
      drive(v);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("rst-mid in wait", {31'd0, rsp_valid}, 32'd0);
      rst_n = 1'b0;
      #2;
      check("rst-mid req_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) seen = 1'b1;
      end
      check("rst-mid no response", {31'd0, seen}, 32'd0);
      check("rst-mid idle", {31'd0, req_ready}, 32'd1);
      do_txn('{1'b0, 2'd0, 1'b0, 32'h40, 32'h0, 32'h11223344, 1'b0}, "rst-mid old value");

      // Misaligned word store and half load
`ifdef DMEM_ALIGN_CHECK_EN
      do_txn('{1'b1, 2'd0, 1'b0, 32'h42, 32'hA5A5A5A5, 32'h0, 1'b1}, "mis store");
      do_txn('{1'b0, 2'd0, 1'b0, 32'h40, 32'h0, 32'h11223344, 1'b0}, "mis after");
      do_txn('{1'b0, 2'd2, 1'b0, 32'h41, 32'h0, 32'h0, 1'b1}, "mis half load");
`else
      do_txn('{1'b1, 2'd0, 1'b0, 32'h42, 32'hA5A5A5A5, 32'h0, 1'b0}, "mis store");
      do_txn('{1'b0, 2'd0, 1'b0, 32'h40, 32'h0, 32'hA5A5A5A5, 1'b0}, "mis after");
      do_txn('{1'b0, 2'd2, 1'b0, 32'h41, 32'h0, 32'h0000A5A5, 1'b0}, "mis half load");
`endif

      // Wrap: store at the top alias, read back at 0
      do_txn('{1'b1, 2'd0, 1'b0, DEPTH * 4, 32'h0BADF00D, 32'h0, 1'b0}, "wrap store");
      do_txn('{1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0BADF00D, 1'b0}, "wrap load");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
